// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// N-master to single-slave memory bus arbiter. The dzcpu (master 0), the
// OAM/HDMA DMA engine and any later masters (debug port) share the one mmu
// port through this block.
//
// Pipeline, one access per cycle:
//   t   : a winner is chosen combinationally from iReq and flagged on oGrant.
//   t+1 : the winner's address / write enable / write data drive the mmu.
//   t+2 : for reads, the mmu's synchronous output is returned on oRdData with
//         oRdValid flagging the owning master.
//
// Arbitration is fixed priority (lowest index wins) or round-robin. A master
// that holds iLock may keep the bus for at most MAX_BURST consecutive grants.
// After that, one arbitration round runs under the normal rules.
//
// Parameter ranges: NUM_MASTERS 1..8, MAX_BURST 2..255.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RR_MODE     = 1,
  parameter int MAX_BURST   = 16
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [NUM_MASTERS-1:0]        iReq,
  input  logic [NUM_MASTERS-1:0]        iLock,
  input  logic [NUM_MASTERS-1:0]        iWe,
  input  logic [NUM_MASTERS*ADDR_W-1:0] iAddr,
  input  logic [NUM_MASTERS*DATA_W-1:0] iData,
  output logic [NUM_MASTERS-1:0]        oGrant,
  output logic [NUM_MASTERS-1:0]        oRdValid,
  output logic [DATA_W-1:0]             oRdData,
  output logic [ADDR_W-1:0]             oMemAddr,
  output logic                          oMemWe,
  output logic [DATA_W-1:0]             oMemData,
  input  logic [DATA_W-1:0]             iMemData
);

  // Master index width. With a single master, a 1-bit index keeps every
  // select legal.
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // Last counter value at which a held lock is still honoured. The counter
  // counts re-grants, so the total locked run is MAX_BURST grants.
  localparam logic [7:0] BURST_CAP = 8'(MAX_BURST - 1);

  // ---------------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rLast;       // most recent winner (round-robin pointer)
  logic             rPrevValid;  // a grant was issued in the previous cycle
  logic [IDX_W-1:0] rPrevIdx;    // the previous cycle's winner
  logic [7:0]       rBurstCnt;   // locked re-grants in the current burst

  // Arbitration result for the current cycle
  logic             lockActive;
  logic             winValid;
  logic [IDX_W-1:0] winIdx;

  // Fields of the winning master
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              selWe;

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic             rIssueRd;    // the access now on the mmu port is a read
  logic [IDX_W-1:0] rIssueIdx;   // owner of the access now on the mmu port
  logic [NUM_MASTERS-1:0] rRdValid;
  logic [DATA_W-1:0]      rRdHold;  // last returned read data

  // Pick this cycle's winner: a held lock first, then round-robin or fixed priority.
  always_comb begin
    int cand;
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    lockActive = 1'b0;
    winValid   = 1'b0;
    winIdx     = '0;
    cand       = 0;

    // No grant is offered while reset is asserted. Anything accepted in that
    // cycle would be wiped from the pipeline at the same edge.
    if (!iReset) begin
      if (rPrevValid && iReq[rPrevIdx] && iLock[rPrevIdx] &&
          (rBurstCnt < BURST_CAP)) begin
        // Burst lock: the previous winner keeps the bus.
        lockActive = 1'b1;
        winValid   = 1'b1;
        winIdx     = rPrevIdx;
      end else if (RR_MODE != 0) begin
        // Round-robin: scan from rLast+1 with wrap-around. The loop runs from
        // the farthest candidate to the nearest, so the nearest requester
        // is written last and wins.
        for (int off = NUM_MASTERS; off >= 1; off--) begin
          cand = int'(rLast) + off;
          if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
          if (iReq[IDX_W'(cand)]) begin
            winValid = 1'b1;
            winIdx   = IDX_W'(cand);
          end
        end
      end else begin
        // Fixed priority: scanning downwards leaves the lowest requester as winner.
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
          if (iReq[IDX_W'(k)]) begin
            winValid = 1'b1;
            winIdx   = IDX_W'(k);
          end
        end
      end
    end
  end

  // Decode the one-hot grant and select the winner's access fields.
  always_comb begin
    oGrant  = winValid ? (NUM_MASTERS'(1) << winIdx) : '0;
    selWe   = iWe[winIdx];
    selAddr = iAddr[winIdx*ADDR_W +: ADDR_W];
    selData = iData[winIdx*DATA_W +: DATA_W];
  end

  // Track the last winner, the round-robin pointer and the burst counter.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      // Pointer starts at the top index, so master 0 is searched first.
      rLast      <= IDX_W'(NUM_MASTERS - 1);
      rPrevValid <= 1'b0;
      rPrevIdx   <= '0;
      rBurstCnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the pre-edge values no matter how the blocks are ordered.
      rPrevValid <= winValid;
      if (winValid) begin
        rPrevIdx <= winIdx;
        rLast    <= winIdx;
      end
      // Count only locked re-grants. An idle cycle, a change of winner, a
      // dropped lock or the cap round all fall to the zero branch.
      rBurstCnt <= lockActive ? rBurstCnt + 8'd1 : 8'd0;
    end
  end

  // Issue stage: register the winner's access onto the mmu port.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      oMemAddr  <= '0;
      oMemWe    <= 1'b0;
      oMemData  <= '0;
      rIssueRd  <= 1'b0;
      rIssueIdx <= '0;
    end else begin
      oMemWe   <= winValid & selWe;
      rIssueRd <= winValid & ~selWe;
      // Address and data hold through idle cycles. oMemWe = 0 makes them inert.
      if (winValid) begin
        oMemAddr  <= selAddr;
        oMemData  <= selData;
        rIssueIdx <= winIdx;
      end
    end
  end

  // Return stage: flag the read owner while the mmu's registered data is on iMemData.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rRdValid <= '0;
      rRdHold  <= '0;
    end else begin
      rRdValid <= rIssueRd ? (NUM_MASTERS'(1) << rIssueIdx) : '0;
      // Capture the data being returned, so oRdData holds it afterwards.
      if (|rRdValid) rRdHold <= iMemData;
    end
  end

  // The mmu output is already registered, so return it directly while valid.
  // Otherwise show the last returned value.
  assign oRdValid = rRdValid;
  assign oRdData  = (|rRdValid) ? iMemData : rRdHold;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Two arbiters (instance 0 round-robin, instance 1 fixed priority, both with
// three masters and MAX_BURST = 4) share one stimulus stream. Each has its own
// behavioural mmu. A reference model of the arbitration rules and of memory
// contents in program order predicts every grant. It pushes the expected mmu
// issue and read return into per-instance queues, and a negedge monitor pops
// and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int N    = 3;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int NI   = 2;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } tIssueItem;

  typedef struct {
    int            due;
    int            master;
    logic [DW-1:0] data;
  } tRdItem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;

  logic [N-1:0]  grant   [NI];
  logic [N-1:0]  rdValid [NI];
  logic [DW-1:0] rdData  [NI];
  logic [AW-1:0] memAddr [NI];
  logic          memWe   [NI];
  logic [DW-1:0] memData [NI];
  logic [DW-1:0] mmuQ    [NI];

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_BURST(MAXB)) dutRr (
    .iClock(clk), .iReset(rst), .iReq(req), .iLock(lock), .iWe(we), .iAddr(addr), .iData(data),
    .oGrant(grant[0]), .oRdValid(rdValid[0]), .oRdData(rdData[0]), .oMemAddr(memAddr[0]),
    .oMemWe(memWe[0]), .oMemData(memData[0]), .iMemData(mmuQ[0]));

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_BURST(MAXB)) dutFp (
    .iClock(clk), .iReset(rst), .iReq(req), .iLock(lock), .iWe(we), .iAddr(addr), .iData(data),
    .oGrant(grant[1]), .oRdValid(rdValid[1]), .oRdData(rdData[1]), .oMemAddr(memAddr[1]),
    .oMemWe(memWe[1]), .oMemData(memData[1]), .iMemData(mmuQ[1]));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit monOn    = 1'b0;

  // Reference model state
  int            prevWin [NI];
  int            runLen  [NI];
  int            rrLast  [NI];
  logic [DW-1:0] lastRd  [NI];
  logic [DW-1:0] refMem  [int];
  logic [DW-1:0] mmuMem  [int];
  tIssueItem     issQ    [NI][$];
  tRdItem        rdQ     [NI][$];

  initial begin
    for (int i = 0; i < NI; i++) begin
      prevWin[i] = -1;
      runLen[i]  = 0;
      rrLast[i]  = N - 1;
      lastRd[i]  = '0;
    end
  end

  function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
    return (a == 16'hC000) ? 8'h5A : (a[7:0] ^ 8'h3C);
  endfunction

  function automatic bit bitAt(input logic [N-1:0] v, input int k);
    return bit'(v >> k);
  endfunction

  function automatic logic [N*AW-1:0] packA(input logic [AW-1:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [N*DW-1:0] packD(input logic [DW-1:0] d0, d1, d2);
    return {d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbitration rules: a locked previous winner keeps the bus while its run
  // is shorter than MAXB grants. Otherwise the instance's base policy applies.
  function automatic int refArb(input int i, output bit viaLock);
    int p;
    int k;
    p = prevWin[i];
    viaLock = 1'b0;
    if (p >= 0 && bitAt(req, p) && bitAt(lock, p) && runLen[i] < MAXB) begin
      viaLock = 1'b1;
      return p;
    end
    if (i == 0) begin
      for (int off = 1; off <= N; off++) begin
        k = (rrLast[i] + off) % N;
        if (bitAt(req, k)) return k;
      end
    end else begin
      for (int m = 0; m < N; m++) if (bitAt(req, m)) return m;
    end
    return -1;
  endfunction

  // Behavioural mmu: registered read of the presented address, write on oMemWe.
  always @(posedge clk) begin
    int key;
    for (int i = 0; i < NI; i++) begin
      key = i * 65536 + int'(memAddr[i]);
      mmuQ[i] <= mmuMem.exists(key) ? mmuMem[key] : initVal(memAddr[i]);
      if (memWe[i] === 1'b1) mmuMem[key] = memData[i];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Apply one cycle of stimulus, check the grant and queue the expected responses.
  task automatic drive(input logic r, input logic [N-1:0] rq, lk, wr,
                       input logic [N*AW-1:0] ad, input logic [N*DW-1:0] dt);
    int w;
    int key;
    bit viaLock;
    tIssueItem it;
    tRdItem rd;
    @(posedge clk);
    #1;
    rst = r; req = rq; lock = lk; we = wr; addr = ad; data = dt;
    #1;
    for (int i = 0; i < NI; i++) begin
      viaLock = 1'b0;
      w = r ? -1 : refArb(i, viaLock);
      check($sformatf("grant%0d", i), 32'(grant[i]), (w < 0) ? 32'd0 : (32'd1 << w));
      if (w >= 0) begin
        it.due  = cyc + 1;
        it.addr = AW'(ad >> (w * AW));
        it.data = DW'(dt >> (w * DW));
        it.we   = bitAt(wr, w);
        issQ[i].push_back(it);
        key = i * 65536 + int'(it.addr);
        if (it.we) refMem[key] = it.data;
        else begin
          rd.due    = cyc + 2;
          rd.master = w;
          rd.data   = refMem.exists(key) ? refMem[key] : initVal(it.addr);
          rdQ[i].push_back(rd);
        end
        runLen[i]  = viaLock ? runLen[i] + 1 : 1;
        prevWin[i] = w;
        rrLast[i]  = w;
      end else begin
        prevWin[i] = -1;
        runLen[i]  = 0;
      end
      if (r) begin
        rrLast[i]  = N - 1;
        prevWin[i] = -1;
        runLen[i]  = 0;
        while (issQ[i].size() > 0 && issQ[i][issQ[i].size()-1].due > cyc) void'(issQ[i].pop_back());
        while (rdQ[i].size() > 0 && rdQ[i][rdQ[i].size()-1].due > cyc) void'(rdQ[i].pop_back());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, '0, '0, '0, '0, '0);
  endtask

  // Monitor: compare the mmu port and the read returns against the queued expectations.
  always @(negedge clk) begin
    tIssueItem it;
    tRdItem rd;
    if (monOn) begin
      for (int i = 0; i < NI; i++) begin
        if (issQ[i].size() > 0 && issQ[i][0].due == cyc) begin
          it = issQ[i].pop_front();
          check($sformatf("memAddr%0d", i), 32'(memAddr[i]), 32'(it.addr));
          check($sformatf("memWe%0d", i), 32'(memWe[i]), 32'(it.we));
          if (it.we) check($sformatf("memData%0d", i), 32'(memData[i]), 32'(it.data));
        end else begin
          check($sformatf("memWeIdle%0d", i), 32'(memWe[i]), 32'd0);
        end

        if (rdValid[i] !== '0) begin
          if (rdQ[i].size() == 0) begin
            check($sformatf("rdValidSpurious%0d", i), 32'(rdValid[i]), 32'd0);
          end else begin
            rd = rdQ[i].pop_front();
            check($sformatf("rdValid%0d", i), 32'(rdValid[i]), 32'd1 << rd.master);
            check($sformatf("rdCycle%0d", i), cyc, rd.due);
            check($sformatf("rdData%0d", i), 32'(rdData[i]), 32'(rd.data));
            lastRd[i] = rd.data;
          end
        end else begin
          if (rdQ[i].size() > 0 && rdQ[i][0].due <= cyc) begin
            rd = rdQ[i].pop_front();
            check($sformatf("rdMissing%0d", i), 32'(rdValid[i]), 32'd1 << rd.master);
          end
          check($sformatf("rdHold%0d", i), 32'(rdData[i]), 32'(lastRd[i]));
        end
        // Reset clears the hold register at the coming edge.
        if (rst) lastRd[i] = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] burstExp [5];
    logic [N-1:0] r3;
    logic [N-1:0] l3;
    logic [N-1:0] w3;
    burstExp = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b010};
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; data = '0;

    // Reset values
    drive(1'b1, '0, '0, '0, '0, '0);
    drive(1'b1, '0, '0, '0, '0, '0);
    monOn = 1'b1;
    for (int i = 0; i < NI; i++) begin
      check("rstGrant",   32'(grant[i]),   32'd0);
      check("rstRdValid", 32'(rdValid[i]), 32'd0);
      check("rstRdData",  32'(rdData[i]),  32'd0);
      check("rstMemAddr", 32'(memAddr[i]), 32'd0);
      check("rstMemWe",   32'(memWe[i]),   32'd0);
      check("rstMemData", 32'(memData[i]), 32'd0);
    end

    // Single read of 0xC000 by master 0
    drive(1'b0, 3'b001, '0, '0, packA(16'hC000, '0, '0), '0);
    idle(3);

    // Contention from reset: round-robin alternates, fixed priority keeps master 0
    drive(1'b1, '0, '0, '0, '0, '0);
    for (int c = 0; c < 6; c++) drive(1'b0, 3'b011, '0, '0, packA(16'hC001, 16'hC002, '0), '0);
    for (int c = 0; c < 2; c++) drive(1'b0, 3'b010, '0, '0, packA(16'hC001, 16'hC002, '0), '0);
    idle(3);

    // DMA burst lock: master 1 locked, master 0 joins
    drive(1'b1, '0, '0, '0, '0, '0);
    drive(1'b0, 3'b010, 3'b010, '0, packA(16'hC004, 16'hC005, '0), '0);
    check("burstFirst", 32'(grant[0]), 32'(3'b010));
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 3'b011, 3'b010, '0, packA(16'hC004, 16'hC005, '0), '0);
      check($sformatf("burst%0d", c), 32'(grant[0]), 32'(burstExp[c]));
    end
    idle(3);

    // Write then read of 0xFE00
    drive(1'b0, 3'b010, '0, 3'b010, packA('0, 16'hFE00, '0), packD('0, 8'h33, '0));
    drive(1'b0, 3'b001, '0, '0, packA(16'hFE00, '0, '0), '0);
    idle(3);

    // Reset in the cycle after a read grant
    drive(1'b0, 3'b001, '0, '0, packA(16'hC003, '0, '0), '0);
    drive(1'b1, '0, '0, '0, '0, '0);
    drive(1'b0, 3'b011, '0, '0, packA(16'hC006, 16'hC007, '0), '0);
    check("postRstRr", 32'(grant[0]), 32'(3'b001));
    check("postRstFp", 32'(grant[1]), 32'(3'b001));
    idle(3);

    // Randomised traffic, heavy locking on master 2, occasional resets
    for (int c = 0; c < 400; c++) begin
      logic [N*AW-1:0] ra;
      logic [N*DW-1:0] rdat;
      r3 = N'($urandom_range(0, 7));
      l3 = N'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 3'b100 : 3'b000);
      w3 = N'($urandom_range(0, 7));
      for (int m = 0; m < N; m++) begin
        ra[m*AW +: AW] = ($urandom_range(0, 7) != 0) ? (16'hC000 + 16'($urandom_range(0, 7))) : 16'hFE00;
        rdat[m*DW +: DW] = DW'($urandom);
      end
      drive(($urandom_range(0, 63) == 0), r3, l3, w3, ra, rdat);
    end

    idle(4);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("issueDrained%0d", i), issQ[i].size(), 32'd0);
      check($sformatf("readDrained%0d", i), rdQ[i].size(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised N-master to single-slave memory bus arbiter.
- Lets the dzcpu, an OAM/HDMA DMA engine and future masters (debug port) share the single mmu port.
- Arbitration is fixed-priority or round-robin, with optional burst locking for DMA.
- Registered request stage plus pipelined one-cycle synchronous mmu read: one access per cycle, fixed 2-cycle read latency.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8); index 0 = CPU.
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- MAX_BURST, 16, maximum consecutive grants a locked master may hold (2..255).

Ports:
- iClock  in  1  system clock.
- iReset  in  1  synchronous active-high reset.
- iReq  in  NUM_MASTERS  per-master access request.
- iLock  in  NUM_MASTERS  per-master burst-lock request.
- iWe  in  NUM_MASTERS  per-master write enable (1 = write, 0 = read).
- iAddr  in  NUM_MASTERS*ADDR_W  packed addresses; master k at [k*ADDR_W +: ADDR_W].
- iData  in  NUM_MASTERS*DATA_W  packed write data.
- oGrant  out  NUM_MASTERS  one-hot, combinational; request accepted at the end of this cycle.
- oRdValid  out  NUM_MASTERS  one-hot, registered; read data valid for master k.
- oRdData  out  DATA_W  read data, shared by all masters, qualified by oRdValid.
- oMemAddr  out  ADDR_W  to mmu iAddr.
- oMemWe  out  1  to mmu iWe.
- oMemData  out  DATA_W  to mmu iData.
- iMemData  in  DATA_W  from mmu oData; valid one cycle after oMemAddr is presented.

Behaviour:
- Clock and reset: single clock iClock. Reset iReset is synchronous, active-high.
- Reset values:
  - oGrant = 0, oRdValid = 0, oRdData = 0, oMemAddr = 0, oMemWe = 0, oMemData = 0.
  - Round-robin pointer rLast = NUM_MASTERS-1, so master 0 has first priority.
  - Burst counter = 0, pipeline valid bits = 0.
- Cycle t, arbitrate:
  - Winner w is selected combinationally from iReq.
  - oGrant[w] = 1. With no request, oGrant = 0.
  - The master may change or drop its request in t+1. A held request in t+1 is a new access.
- Cycle t+1, issue:
  - oMemAddr, oMemWe and oMemData are registered copies of master w's fields.
  - oMemWe is 0 whenever no access was granted in t.
- Cycle t+2, read return:
  - For reads, oRdValid[w] = 1 and oRdData = iMemData.
  - Writes never assert oRdValid.
  - oRdData holds its last value when oRdValid = 0.
- Throughput: one grant per cycle; back-to-back accesses from any masters are fully pipelined.
- Fixed priority (RR_MODE = 0): lowest requesting index wins.
- Round-robin (RR_MODE = 1):
  - Search begins at rLast+1 modulo NUM_MASTERS.
  - rLast updates to w on every grant.
- Lock:
  - Applies only when the previous cycle's winner p has iReq[p] & iLock[p], and the burst counter is below MAX_BURST-1. Then p wins regardless of mode.
  - The counter increments on each locked re-grant.
  - The counter clears when the winner changes, when the lock drops, or on an idle cycle.
- Burst cap:
  - At counter = MAX_BURST-1 the lock is ignored for one arbitration (normal rules apply) and the counter clears.
  - In round-robin mode the locked master therefore loses to any other requester.
  - In fixed-priority mode a lower-index requester wins; otherwise p may win again.
- Edge cases:
  - Simultaneous read and write from different masters serialise by arbitration; there is no combining.
  - iLock without iReq is ignored.
  - NUM_MASTERS = 1: oGrant = iReq, and behaviour is otherwise identical.
- Reset mid-operation: in-flight issue and return stages are discarded. No oRdValid and no oMemWe are issued in the cycle after reset.

Test Plan:
- Single read: master 0 reads 0xC000, mmu holds 0x5A. Required: oGrant = 01 at t, oMemAddr = 0xC000 and oMemWe = 0 at t+1, oRdValid = 01 and oRdData = 0x5A at t+2.
- Contention, round-robin: both masters request continuously from reset. Required: grants alternate 0,1,0,1; each oRdValid follows its grant by 2 cycles.
- Fixed priority (RR_MODE = 0): both request for 4 cycles. Required: master 1 is never granted until master 0 drops iReq.
- DMA burst lock (MAX_BURST = 4): master 1 locked, master 0 requesting. Required: master 1 granted 4 consecutive cycles, then master 0 granted, then master 1.
- Write then read: master 1 writes 0xFE00 = 0x33, then master 0 reads 0xFE00. Required: oMemWe = 1 for exactly one cycle, no oRdValid for the write, read returns 0x33.
- Reset mid-read: assert iReset in the cycle after a grant. Required: oRdValid stays 0 and oMemWe stays 0; master 0 is granted first after reset.
